// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: headings, FSM states, map
// position struct, default game dimensions and the heading-reversal helper.
package snake_pkg;

  localparam int MAX_SNAKE_LENGTH = 15;
  localparam int MAP_WIDTH        = 64;
  localparam int MAP_HEIGHT       = 48;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } direction;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    CHECK = 2'd2,
    DEAD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [$clog2(MAP_WIDTH)-1:0]  x;
    logic [$clog2(MAP_HEIGHT)-1:0] y;
  } pos_t;

  // Heading that would reverse the snake onto its own neck.
  function automatic direction opposite(input direction d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: resolves the effective heading
// (ignores NONE and reversals) and steps the head one tile along it.
// Leaving the map flags out-of-bounds, or wraps around when the
// SNAKE_WRAP_EN macro is defined.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int MAP_W = 64,
  parameter int MAP_H = 48,
  parameter int XW    = $clog2(MAP_W),
  parameter int YW    = $clog2(MAP_H)
) (
  input  logic [XW-1:0] head_x_i,
  input  logic [YW-1:0] head_y_i,
  input  direction      heading_i,
  input  direction      dir_i,
  output logic [XW-1:0] nxt_x_o,
  output logic [YW-1:0] nxt_y_o,
  output direction      eff_dir_o,
  output logic          oob_o
);

  // Pick the heading, then move one tile on the matching axis.
  // NOTE: every output gets a default before the case so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    eff_dir_o = heading_i;
    nxt_x_o   = head_x_i;
    nxt_y_o   = head_y_i;
    oob_o     = 1'b0;
    if (dir_i != NONE && dir_i != opposite(heading_i)) begin
      eff_dir_o = dir_i;
    end
    case (eff_dir_o)
      RIGHT: begin
        if (head_x_i == XW'(MAP_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          nxt_x_o = '0;
`else
          oob_o = 1'b1;
`endif
        end else begin
          nxt_x_o = head_x_i + XW'(1);
        end
      end
      LEFT: begin
        if (head_x_i == '0) begin
`ifdef SNAKE_WRAP_EN
          nxt_x_o = XW'(MAP_W - 1);
`else
          oob_o = 1'b1;
`endif
        end else begin
          nxt_x_o = head_x_i - XW'(1);
        end
      end
      DOWN: begin
        if (head_y_i == YW'(MAP_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          nxt_y_o = '0;
`else
          oob_o = 1'b1;
`endif
        end else begin
          nxt_y_o = head_y_i + YW'(1);
        end
      end
      UP: begin
        if (head_y_i == '0) begin
`ifdef SNAKE_WRAP_EN
          nxt_y_o = YW'(MAP_H - 1);
`else
          oob_o = 1'b1;
`endif
        end else begin
          nxt_y_o = head_y_i - YW'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/snake_body.sv
// Per-player snake body engine. Keeps the head, heading and a ring buffer
// of segments; each accepted step runs IDLE -> MOVE -> CHECK and either
// commits the move (optionally growing) or latches a sticky death.
// A registered query port tells the renderer whether a tile is occupied.
// Optional torus wrap-around is enabled with the SNAKE_WRAP_EN macro.
module snake_body
  import snake_pkg::*;
#(
  parameter int       MAX_LEN  = MAX_SNAKE_LENGTH,
  parameter int       MAP_W    = MAP_WIDTH,
  parameter int       MAP_H    = MAP_HEIGHT,
  parameter int       INIT_LEN = 3,
  parameter int       INIT_X   = 8,
  parameter int       INIT_Y   = 24,
  parameter direction INIT_DIR = RIGHT,
  parameter int       XW       = $clog2(MAP_W),
  parameter int       YW       = $clog2(MAP_H),
  parameter int       LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          step,
  input  direction      dir_in,
  input  logic          grow,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          dead,
  output logic          step_done,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          query_hit,
  output logic          query_head
);

  localparam int PW = $clog2(MAX_LEN);

  state_e        state_q, state_d;
  direction      heading_q, dir_lat_q, eff_dir;
  logic          grow_lat_q;
  logic [XW-1:0] head_x_q, nxt_x_q, nxt_x_c;
  logic [YW-1:0] head_y_q, nxt_y_q, nxt_y_c;
  logic          oob_q, oob_c;
  logic [PW-1:0] head_ptr_q, head_ptr_nxt;
  logic [LW-1:0] length_q;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic          step_done_q, query_hit_q, query_head_q;
  logic [MAX_LEN-1:0] live, tail;
  logic          can_grow, body_hit, query_hit_c;
  logic          accept, commit, die;

  // Reset-pose coordinates of the segment 'age' tiles behind the head.
  function automatic int init_px(input int age);
    case (INIT_DIR)
      RIGHT:   return INIT_X - age;
      LEFT:    return INIT_X + age;
      default: return INIT_X;
    endcase
  endfunction

  function automatic int init_py(input int age);
    case (INIT_DIR)
      DOWN:    return INIT_Y - age;
      UP:      return INIT_Y + age;
      default: return INIT_Y;
    endcase
  endfunction

  snake_next_head #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .XW    (XW),
    .YW    (YW)
  ) u_next_head (
    .head_x_i  (head_x_q),
    .head_y_i  (head_y_q),
    .heading_i (heading_q),
    .dir_i     (dir_lat_q),
    .nxt_x_o   (nxt_x_c),
    .nxt_y_o   (nxt_y_c),
    .eff_dir_o (eff_dir),
    .oob_o     (oob_c)
  );

  assign head_ptr_nxt = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + PW'(1);
  assign can_grow     = grow_lat_q && (int'(length_q) < MAX_LEN);

  // Classify ring entries by age behind the head: live body and the tail.
  always_comb begin
    live = '0;
    tail = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      automatic int age = int'(head_ptr_q) - i;
      if (age < 0) age = age + MAX_LEN;
      live[i] = age < int'(length_q);
      tail[i] = age == int'(length_q) - 1;
    end
  end

  // Collision against the body (the tail is free unless it stays put) and
  // occupancy of the queried tile.
  always_comb begin
    body_hit    = 1'b0;
    query_hit_c = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (live[i] && !(tail[i] && !can_grow) &&
          seg_x_q[i] == nxt_x_q && seg_y_q[i] == nxt_y_q) begin
        body_hit = 1'b1;
      end
      if (live[i] && seg_x_q[i] == query_x && seg_y_q[i] == query_y) begin
        query_hit_c = 1'b1;
      end
    end
  end

  // Next-state and control strobes; restart overrides everything.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    die     = 1'b0;
    case (state_q)
      IDLE: begin
        if (step) begin
          state_d = MOVE;
          accept  = 1'b1;
        end
      end
      MOVE:  state_d = CHECK;
      CHECK: begin
        if (body_hit || oob_q) begin
          state_d = DEAD;
          die     = 1'b1;
        end else begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      DEAD:    state_d = DEAD;
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = IDLE;
      accept  = 1'b0;
      commit  = 1'b0;
      die     = 1'b0;
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Body datapath: pose load, request latch, next-head capture, commit.
  // NOTE: the segment ring is reset on purpose; restart has to rebuild the
  // starting body anyway and the array is only MAX_LEN entries deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heading_q   <= INIT_DIR;
      dir_lat_q   <= NONE;
      grow_lat_q  <= 1'b0;
      head_x_q    <= XW'(INIT_X);
      head_y_q    <= YW'(INIT_Y);
      nxt_x_q     <= '0;
      nxt_y_q     <= '0;
      oob_q       <= 1'b0;
      head_ptr_q  <= PW'(INIT_LEN - 1);
      length_q    <= LW'(INIT_LEN);
      step_done_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? XW'(init_px(INIT_LEN - 1 - i)) : '0;
        seg_y_q[i] <= (i < INIT_LEN) ? YW'(init_py(INIT_LEN - 1 - i)) : '0;
      end
    end else if (restart) begin
      heading_q   <= INIT_DIR;
      grow_lat_q  <= 1'b0;
      head_x_q    <= XW'(INIT_X);
      head_y_q    <= YW'(INIT_Y);
      head_ptr_q  <= PW'(INIT_LEN - 1);
      length_q    <= LW'(INIT_LEN);
      step_done_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? XW'(init_px(INIT_LEN - 1 - i)) : '0;
        seg_y_q[i] <= (i < INIT_LEN) ? YW'(init_py(INIT_LEN - 1 - i)) : '0;
      end
    end else begin
      step_done_q <= commit | die;
      if (accept) begin
        dir_lat_q  <= dir_in;
        grow_lat_q <= grow;
      end
      if (state_q == MOVE) begin
        nxt_x_q <= nxt_x_c;
        nxt_y_q <= nxt_y_c;
        oob_q   <= oob_c;
      end
      if (commit) begin
        seg_x_q[head_ptr_nxt] <= nxt_x_q;
        seg_y_q[head_ptr_nxt] <= nxt_y_q;
        head_ptr_q            <= head_ptr_nxt;
        head_x_q              <= nxt_x_q;
        head_y_q              <= nxt_y_q;
        heading_q             <= eff_dir;
        if (can_grow) length_q <= length_q + LW'(1);
      end
    end
  end

  // Registered tile query, reflecting the body before any same-edge commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_hit_q  <= 1'b0;
      query_head_q <= 1'b0;
    end else begin
      query_hit_q  <= query_hit_c;
      query_head_q <= (query_x == head_x_q) && (query_y == head_y_q);
    end
  end

  assign head_x     = head_x_q;
  assign head_y     = head_y_q;
  assign length     = length_q;
  assign busy       = (state_q == MOVE) || (state_q == CHECK);
  assign dead       = (state_q == DEAD);
  assign step_done  = step_done_q;
  assign query_hit  = query_hit_q;
  assign query_head = query_head_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with default parameters (64x48 map,
// 15 segments, start (8,24) heading RIGHT, length 3). Expected values are
// hand-derived; wall behaviour follows SNAKE_WRAP_EN.
module tb_snake_body;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, restart, step, grow;
  direction   dir_in;
  logic [5:0] head_x, head_y, query_x, query_y;
  logic [3:0] length;
  logic       busy, dead, step_done, query_hit, query_head;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snake_body dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .step       (step),
    .dir_in     (dir_in),
    .grow       (grow),
    .head_x     (head_x),
    .head_y     (head_y),
    .length     (length),
    .busy       (busy),
    .dead       (dead),
    .step_done  (step_done),
    .query_x    (query_x),
    .query_y    (query_y),
    .query_hit  (query_hit),
    .query_head (query_head)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pose(input string tag, input int x, input int y, input int len);
    check({tag, "_x"}, head_x, x);
    check({tag, "_y"}, head_y, y);
    check({tag, "_len"}, length, len);
  endtask

  // One full tick: E0 accept, E1 MOVE->CHECK, E2 commit; step_done after E2.
  task automatic do_step(input direction d, input logic g, input logic exp_dead);
    @(negedge clk);
    step = 1'b1; dir_in = d; grow = g;
    @(posedge clk); #1;
    step = 1'b0; dir_in = NONE; grow = 1'b0;
    check("busy_e0", busy, 1);
    @(posedge clk); #1;
    check("busy_e1", busy, 1);
    check("done_e1", step_done, 0);
    @(posedge clk); #1;
    check("done_e2", step_done, 1);
    check("busy_e2", busy, 0);
    check("dead_e2", dead, exp_dead);
  endtask

  task automatic do_query(input int x, input int y, input logic hit, input logic hd);
    @(negedge clk);
    query_x = 6'(x); query_y = 6'(y);
    @(posedge clk); #1;
    check("q_hit", query_hit, hit);
    check("q_head", query_head, hd);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    check_pose("restart", 8, 24, 3);
    check("restart_dead", dead, 0);
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; step = 1'b0; grow = 1'b0;
    dir_in = NONE; query_x = '0; query_y = '0;
    #22;
    check_pose("rst", 8, 24, 3);
    check("rst_busy", busy, 0);
    check("rst_dead", dead, 0);
    check("rst_done", step_done, 0);
    check("rst_qhit", query_hit, 0);
    check("rst_qhead", query_head, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initial body (8,24) (7,24) (6,24).
    do_query(6, 24, 1, 0);
    do_query(5, 24, 0, 0);
    do_query(8, 24, 1, 1);
    do_query(9, 24, 0, 0);

    // Turn UP: body becomes (8,23) (8,24) (7,24).
    do_step(UP, 0, 0);
    check_pose("up", 8, 23, 3);
    do_query(6, 24, 0, 0);
    do_query(7, 24, 1, 0);
    do_query(8, 23, 1, 1);

    // Reversal LEFT while heading RIGHT is ignored.
    do_restart();
    do_step(LEFT, 0, 0);
    check_pose("reverse", 9, 24, 3);

    // Growth from 3 saturates at 15; the 13th grow just moves.
    for (int i = 0; i < 13; i++) begin
      do_step(RIGHT, 1, 0);
      check("grow_len", length, (4 + i > 15) ? 15 : 4 + i);
    end
    check_pose("grown", 22, 24, 15);
    do_query(7, 24, 0, 0);
    do_query(8, 24, 1, 0);

    // Run to the right wall.
    for (int i = 0; i < 41; i++) do_step(RIGHT, 0, 0);
    check_pose("at_wall", 63, 24, 15);
`ifdef SNAKE_WRAP_EN
    do_step(RIGHT, 0, 0);
    check_pose("wrap", 0, 24, 15);
`else
    do_step(RIGHT, 0, 1);
    check_pose("wall_dead", 63, 24, 15);
    // Steps while dead are ignored.
    @(negedge clk);
    step = 1'b1; dir_in = UP;
    @(posedge clk); #1;
    step = 1'b0; dir_in = NONE;
    for (int k = 0; k < 3; k++) begin
      check("dead_busy", busy, 0);
      check("dead_done", step_done, 0);
      @(posedge clk); #1;
    end
    check("dead_hold", dead, 1);
    check_pose("dead_pose", 63, 24, 15);
`endif

    // Self collision: grow to 5, then UP, LEFT, DOWN into the body.
    do_restart();
    do_step(RIGHT, 1, 0);
    do_step(RIGHT, 1, 0);
    check_pose("len5", 10, 24, 5);
    do_step(UP, 0, 0);
    check_pose("loop_up", 10, 23, 5);
    do_step(LEFT, 0, 0);
    check_pose("loop_left", 9, 23, 5);
    do_step(DOWN, 0, 1);
    check_pose("self_hit", 9, 23, 5);

    // Restart together with step: restart wins, no step_done.
    @(negedge clk);
    restart = 1'b1; step = 1'b1; dir_in = UP;
    @(posedge clk); #1;
    restart = 1'b0; step = 1'b0; dir_in = NONE;
    check_pose("rs_step", 8, 24, 3);
    check("rs_dead", dead, 0);
    check("rs_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      check("rs_done", step_done, 0);
      @(posedge clk); #1;
    end

    // Restart aborting an in-flight step.
    @(negedge clk);
    step = 1'b1; dir_in = UP;
    @(posedge clk); #1;
    step = 1'b0; dir_in = NONE;
    check("abort_busy0", busy, 1);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    check("abort_busy1", busy, 0);
    for (int k = 0; k < 3; k++) begin
      check("abort_done", step_done, 0);
      @(posedge clk); #1;
    end
    check_pose("abort", 8, 24, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
